// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the accumulator CPU control path: opcodes, sequencer
// states, ALU operation codes and the control-strobe word.
package cpu_ctrl_pkg;

    typedef enum logic [3:0] {
        OP_NOP  = 4'h0,
        OP_LDI  = 4'h1,
        OP_LDA  = 4'h2,
        OP_STA  = 4'h3,
        OP_ADD  = 4'h4,
        OP_SUB  = 4'h5,
        OP_AND  = 4'h6,
        OP_OR   = 4'h7,
        OP_XOR  = 4'h8,
        OP_NOT  = 4'h9,
        OP_JMP  = 4'hA,
        OP_JZ   = 4'hB,
        OP_JNZ  = 4'hC,
        OP_ADDI = 4'hD,
        OP_ILL  = 4'hE,
        OP_HLT  = 4'hF
    } opcode_e;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_HALT   = 3'd4
    } state_e;

    typedef enum logic [2:0] {
        ALU_PASSB = 3'b000,
        ALU_ADD   = 3'b001,
        ALU_SUB   = 3'b010,
        ALU_AND   = 3'b011,
        ALU_OR    = 3'b100,
        ALU_XOR   = 3'b101,
        ALU_NOTA  = 3'b110
    } alu_op_e;

    typedef struct packed {
        logic       load_ir;
        logic       inc_pc;
        logic       load_pc;
        logic       addr_sel;
        logic       mem_read;
        logic       mem_write;
        logic [2:0] alu_op;
        logic       alu_b_sel;
        logic       load_acc;
        logic       load_flags;
        logic       illegal_op;
    } ctrl_t;

    // Opcodes that need a second memory-read cycle (MEM state) to finish.
    function automatic logic is_mem_read_op(input logic [3:0] op);
        logic res;
        case (op)
            OP_LDA, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: res = 1'b1;
            default:                                       res = 1'b0;
        endcase
        return res;
    endfunction

    function automatic logic [2:0] mem_alu_op(input logic [3:0] op);
        logic [2:0] res;
        case (op)
            OP_ADD:  res = ALU_ADD;
            OP_SUB:  res = ALU_SUB;
            OP_AND:  res = ALU_AND;
            OP_OR:   res = ALU_OR;
            OP_XOR:  res = ALU_XOR;
            default: res = ALU_PASSB;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational map from (state, opcode, zero_flag, mem_ready) to the
// control-strobe word. Unreachable states produce no strobes.
module ctrl_decode
    import cpu_ctrl_pkg::*;
(
    input  logic [2:0] i_state,
    input  logic [3:0] i_opcode,
    input  logic       i_zero_flag,
    input  logic       i_mem_ready,
    output ctrl_t      o_ctrl
);

    // Strobe generation per state and opcode.
    always_comb begin
        o_ctrl = '0;
        case (i_state)
            ST_FETCH: begin
                o_ctrl.addr_sel = 1'b0;
                o_ctrl.mem_read = 1'b1;
                o_ctrl.load_ir  = i_mem_ready;
            end
            ST_DECODE: begin
                o_ctrl.inc_pc = 1'b1;
            end
            ST_EXEC: begin
                case (i_opcode)
                    OP_LDI: begin
                        o_ctrl.alu_op    = ALU_PASSB;
                        o_ctrl.alu_b_sel = 1'b1;
                        o_ctrl.load_acc  = 1'b1;
                    end
                    OP_ADDI: begin
                        o_ctrl.alu_op     = ALU_ADD;
                        o_ctrl.alu_b_sel  = 1'b1;
                        o_ctrl.load_acc   = 1'b1;
                        o_ctrl.load_flags = 1'b1;
                    end
                    OP_NOT: begin
                        o_ctrl.alu_op     = ALU_NOTA;
                        o_ctrl.load_acc   = 1'b1;
                        o_ctrl.load_flags = 1'b1;
                    end
                    OP_JMP: o_ctrl.load_pc = 1'b1;
                    OP_JZ:  o_ctrl.load_pc = i_zero_flag;
                    OP_JNZ: o_ctrl.load_pc = ~i_zero_flag;
                    OP_STA: begin
                        o_ctrl.addr_sel  = 1'b1;
                        o_ctrl.mem_write = 1'b1;
                    end
                    OP_LDA, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
                        o_ctrl.addr_sel = 1'b1;
                        o_ctrl.mem_read = 1'b1;
                    end
                    OP_ILL:  o_ctrl.illegal_op = 1'b1;
                    default: o_ctrl = '0;
                endcase
            end
            ST_MEM: begin
                // LDA only moves data; the flags keep the previous ALU result.
                o_ctrl.addr_sel   = 1'b1;
                o_ctrl.mem_read   = 1'b1;
                o_ctrl.alu_b_sel  = 1'b0;
                o_ctrl.alu_op     = mem_alu_op(i_opcode);
                o_ctrl.load_acc   = i_mem_ready;
                o_ctrl.load_flags = (i_opcode == OP_LDA) ? 1'b0 : i_mem_ready;
            end
            default: o_ctrl = '0;
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// Multi-cycle control sequencer: state register, retired-instruction counter,
// halt status and reset gating around the ctrl_decode strobe map.
module control_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [3:0]       opcode,
    input  logic             zero_flag,
    input  logic             mem_ready,
    output logic             LoadIR,
    output logic             IncPC,
    output logic             LoadPC,
    output logic             addr_sel,
    output logic             mem_read,
    output logic             mem_write,
    output logic [2:0]       alu_op,
    output logic             alu_b_sel,
    output logic             LoadAcc,
    output logic             LoadFlags,
    output logic             halted,
    output logic             illegal_op,
    output logic [2:0]       state_out,
    output logic [CNT_W-1:0] instr_count
);

    state_e           r_state;
    state_e           w_state_next;
    logic             w_retire;
    logic [CNT_W-1:0] r_count;
    logic             r_halted;
    ctrl_t            w_ctrl;
    ctrl_t            w_ctrl_gated;

    ctrl_decode u_decode (
        .i_state     (r_state),
        .i_opcode    (opcode),
        .i_zero_flag (zero_flag),
        .i_mem_ready (mem_ready),
        .o_ctrl      (w_ctrl)
    );

    // Next-state selection and retire detection.
    always_comb begin
        w_state_next = ST_FETCH;
        w_retire     = 1'b0;
        case (r_state)
            ST_FETCH:  w_state_next = mem_ready ? ST_DECODE : ST_FETCH;
            ST_DECODE: w_state_next = (opcode == OP_HLT) ? ST_HALT : ST_EXEC;
            ST_EXEC: begin
                if (is_mem_read_op(opcode)) begin
                    w_state_next = ST_MEM;
                    w_retire     = 1'b0;
                end else if (opcode == OP_STA) begin
                    w_state_next = mem_ready ? ST_FETCH : ST_EXEC;
                    w_retire     = mem_ready;
                end else begin
                    w_state_next = ST_FETCH;
                    w_retire     = 1'b1;
                end
            end
            ST_MEM: begin
                w_state_next = mem_ready ? ST_FETCH : ST_MEM;
                w_retire     = mem_ready;
            end
            ST_HALT: w_state_next = ST_HALT;
            default: w_state_next = ST_FETCH;
        endcase
    end

    // State register, retire counter and halt flag.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state  <= ST_FETCH;
            r_count  <= {CNT_W{1'b0}};
            r_halted <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_halted <= (w_state_next == ST_HALT);
            if (w_retire) begin
                r_count <= r_count + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    // An in-flight instruction is abandoned during reset, so nothing may strobe.
    assign w_ctrl_gated = reset ? '0 : w_ctrl;

    assign LoadIR      = w_ctrl_gated.load_ir;
    assign IncPC       = w_ctrl_gated.inc_pc;
    assign LoadPC      = w_ctrl_gated.load_pc;
    assign addr_sel    = w_ctrl_gated.addr_sel;
    assign mem_read    = w_ctrl_gated.mem_read;
    assign mem_write   = w_ctrl_gated.mem_write;
    assign alu_op      = w_ctrl_gated.alu_op;
    assign alu_b_sel   = w_ctrl_gated.alu_b_sel;
    assign LoadAcc     = w_ctrl_gated.load_acc;
    assign LoadFlags   = w_ctrl_gated.load_flags;
    assign illegal_op  = w_ctrl_gated.illegal_op;
    assign halted      = r_halted;
    assign state_out   = r_state;
    assign instr_count = r_count;

endmodule
